// File: rtl/mem_access_unit.sv
// MIPS memory-access stage: loads/stores over a req/ack bus with big-endian lane handling.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses without touching the bus.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic        stallreq_o,
  output logic        valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] TO_LAST    = 8'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  wd_lat_q, wd_lat_d, wd_d;
  logic        wreg_lat_q, wreg_lat_d;
  logic        valid_d, wreg_d, req_d, we_d, err_d, mis_d;
  logic [31:0] wdata_d, addr_d, bwdata_d;
  logic [3:0]  sel_d;
  logic        is_mem_s, is_store_s, misalign_s;
  logic [1:0]  size_s;
  logic [3:0]  sel_s;
  logic [31:0] st_data_s, ld_data_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Decode the incoming op into access size, direction and byte lanes
  always_comb begin
    is_mem_s   = 1'b0;
    is_store_s = 1'b0;
    size_s     = 2'd0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin is_mem_s = 1'b1; size_s = 2'd0; end
      EXE_LH_OP, EXE_LHU_OP: begin is_mem_s = 1'b1; size_s = 2'd1; end
      EXE_LW_OP:             begin is_mem_s = 1'b1; size_s = 2'd2; end
      EXE_SB_OP: begin is_mem_s = 1'b1; is_store_s = 1'b1; size_s = 2'd0; end
      EXE_SH_OP: begin is_mem_s = 1'b1; is_store_s = 1'b1; size_s = 2'd1; end
      EXE_SW_OP: begin is_mem_s = 1'b1; is_store_s = 1'b1; size_s = 2'd2; end
      default: begin is_mem_s = 1'b0; is_store_s = 1'b0; size_s = 2'd0; end
    endcase
    case (size_s)
      2'd0: begin sel_s = 4'b1000 >> mem_addr_i[1:0]; st_data_s = {4{reg2_i[7:0]}}; end
      2'd1: begin sel_s = mem_addr_i[1] ? 4'b0011 : 4'b1100; st_data_s = {2{reg2_i[15:0]}}; end
      default: begin sel_s = 4'b1111; st_data_s = reg2_i; end
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    misalign_s = is_mem_s && (((size_s == 2'd1) && mem_addr_i[0]) ||
                              ((size_s == 2'd2) && (mem_addr_i[1:0] != 2'b00)));
`else
    misalign_s = 1'b0;
`endif
  end

  // Pick the addressed lane out of the returned word and extend it (big-endian)
  always_comb begin
    case (off_q)
      2'd0:    byte_s = bus_rdata_i[31:24];
      2'd1:    byte_s = bus_rdata_i[23:16];
      2'd2:    byte_s = bus_rdata_i[15:8];
      default: byte_s = bus_rdata_i[7:0];
    endcase
    half_s = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (op_q)
      EXE_LB_OP:  ld_data_s = {{24{byte_s[7]}}, byte_s};
      EXE_LBU_OP: ld_data_s = {24'd0, byte_s};
      EXE_LH_OP:  ld_data_s = {{16{half_s[15]}}, half_s};
      EXE_LHU_OP: ld_data_s = {16'd0, half_s};
      EXE_LW_OP:  ld_data_s = bus_rdata_i;
      default:    ld_data_s = 32'd0;
    endcase
  end

  // Next-state, stall and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    off_d      = off_q;
    wd_lat_d   = wd_lat_q;
    wreg_lat_d = wreg_lat_q;
    valid_d    = 1'b0;
    wreg_d     = 1'b0;
    wd_d       = wd_o;
    wdata_d    = wdata_o;
    req_d      = bus_req_o;
    we_d       = bus_we_o;
    addr_d     = bus_addr_o;
    sel_d      = bus_sel_o;
    bwdata_d   = bus_wdata_o;
    err_d      = 1'b0;
    mis_d      = 1'b0;
    stallreq_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && is_mem_s && !misalign_s) begin
          stallreq_o = 1'b1;
          state_d    = BUSY;
          cnt_d      = 8'd0;
          op_d       = aluop_i;
          off_d      = mem_addr_i[1:0];
          wd_lat_d   = wd_i;
          wreg_lat_d = wreg_i;
          req_d      = 1'b1;
          we_d       = is_store_s;
          addr_d     = {mem_addr_i[31:2], 2'b00};
          sel_d      = sel_s;
          bwdata_d   = st_data_s;
        end else if (valid_i && is_mem_s) begin
          valid_d = 1'b1;
          wd_d    = wd_i;
          wdata_d = 32'd0;
          mis_d   = 1'b1;
        end else if (valid_i) begin
          valid_d = 1'b1;
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          wdata_d = wdata_i;
        end else begin
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          wd_d    = wd_lat_q;
          wreg_d  = bus_we_o ? 1'b0 : wreg_lat_q;
          wdata_d = bus_we_o ? 32'd0 : ld_data_s;
        end else if (cnt_q == TO_LAST) begin
          // Abort: the missing ack still retires the slot, but with no write-back
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          wd_d    = wd_lat_q;
          wdata_d = 32'd0;
        end else begin
          stallreq_o = 1'b1;
          cnt_d      = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      op_q        <= 8'd0;
      off_q       <= 2'd0;
      wd_lat_q    <= 5'd0;
      wreg_lat_q  <= 1'b0;
      valid_o     <= 1'b0;
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= 32'd0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_sel_o   <= 4'd0;
      bus_wdata_o <= 32'd0;
      bus_err_o   <= 1'b0;
      misalign_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      wd_lat_q    <= wd_lat_d;
      wreg_lat_q  <= wreg_lat_d;
      valid_o     <= valid_d;
      wd_o        <= wd_d;
      wreg_o      <= wreg_d;
      wdata_o     <= wdata_d;
      bus_req_o   <= req_d;
      bus_we_o    <= we_d;
      bus_addr_o  <= addr_d;
      bus_sel_o   <= sel_d;
      bus_wdata_o <= bwdata_d;
      bus_err_o   <= err_d;
      misalign_o  <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (ACK_TIMEOUT=4); honours MEM_ALIGN_CHECK_EN if defined.
module tb_mem_access_unit;
  localparam logic [7:0] ADD_OP = 8'b0010_0000;
  localparam logic [7:0] LB_OP  = 8'b1110_0000;
  localparam logic [7:0] LH_OP  = 8'b1110_0001;
  localparam logic [7:0] LHU_OP = 8'b1110_0101;
  localparam logic [7:0] LW_OP  = 8'b1110_0011;
  localparam logic [7:0] SH_OP  = 8'b1110_1001;
  localparam logic [7:0] SW_OP  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst, valid_i, wreg_i, bus_ack_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        stallreq_o, valid_o, wreg_o, bus_req_o, bus_we_o, bus_err_o, misalign_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  int          total = 0;
  int          passed = 0;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .stallreq_o(stallreq_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                       input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = r2;
    wd_i = wd; wreg_i = wr; wdata_i = wdat;
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; aluop_i = 8'd0; mem_addr_i = 32'd0; reg2_i = 32'd0;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0; bus_rdata_i = 32'd0; bus_ack_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_err_mis", {bus_err_o, misalign_o, wreg_o}, 0);
    chk("rst_stall", stallreq_o, 0);

    // ADD passthrough
    issue(ADD_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h12345678);
    chk("add_stall", stallreq_o, 0);
    tick(); valid_i = 1'b0; #1;
    chk("add_valid", valid_o, 1);
    chk("add_wd", wd_o, 5);
    chk("add_wdata", wdata_o, 32'h12345678);
    chk("add_wreg_req", {wreg_o, bus_req_o}, 2'b10);
    tick();
    chk("idle_valid", {valid_o, wreg_o}, 2'b00);

    // LB 0x103, zero-wait ack
    issue(LB_OP, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0);
    chk("lb_stall_n", stallreq_o, 1);
    tick(); valid_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h112233F0; #1;
    chk("lb_req", {bus_req_o, bus_we_o}, 2'b10);
    chk("lb_sel", bus_sel_o, 4'b0001);
    chk("lb_addr", bus_addr_o, 32'h100);
    chk("lb_stall_ack", stallreq_o, 0);
    tick(); bus_ack_i = 1'b0; #1;
    chk("lb_valid", {valid_o, wreg_o, bus_req_o}, 3'b110);
    chk("lb_wd", wd_o, 7);
    chk("lb_wdata", wdata_o, 32'hFFFFFFF0);

    // SH 0x202 with 3 wait cycles (ack on the last allowed BUSY cycle)
    issue(SH_OP, 32'h202, 32'hAAAABEEF, 5'd9, 1'b1, 32'h0);
    chk("sh_stall_n", stallreq_o, 1);
    tick(); valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_ack_i = 1'b1;
      #1;
      chk("sh_req_we", {bus_req_o, bus_we_o}, 2'b11);
      chk("sh_sel", bus_sel_o, 4'b0011);
      chk("sh_bwdata", bus_wdata_o, 32'hBEEFBEEF);
      chk("sh_addr", bus_addr_o, 32'h200);
      chk("sh_stall", stallreq_o, (i == 3) ? 32'd0 : 32'd1);
      tick();
    end
    bus_ack_i = 1'b0; #1;
    chk("sh_done", {valid_o, wreg_o, bus_req_o, bus_err_o}, 4'b1000);

    // LW with no ack: timeout after 4 BUSY cycles
    issue(LW_OP, 32'h300, 32'h0, 5'd4, 1'b1, 32'h0);
    tick(); valid_i = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", bus_req_o, 1);
      chk("to_stall", stallreq_o, (i == 3) ? 32'd0 : 32'd1);
      tick();
    end
    chk("to_err", {bus_err_o, bus_req_o, valid_o, wreg_o}, 4'b1010);
    chk("to_idle_stall", stallreq_o, 0);
    tick();
    chk("to_err_pulse", {bus_err_o, valid_o}, 2'b00);

    // LH 0x101: misaligned when the check is built in, otherwise a normal load
    issue(LH_OP, 32'h101, 32'h0, 5'd11, 1'b1, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("lh_mis_stall", stallreq_o, 0);
    tick(); valid_i = 1'b0; #1;
    chk("lh_mis", {misalign_o, valid_o, wreg_o, bus_req_o}, 4'b1100);
    tick();
    chk("lh_mis_pulse", {misalign_o, bus_req_o}, 2'b00);
`else
    chk("lh_stall", stallreq_o, 1);
    tick(); valid_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hBEEF1234; #1;
    chk("lh_sel", bus_sel_o, 4'b1100);
    chk("lh_addr", bus_addr_o, 32'h100);
    tick(); bus_ack_i = 1'b0; #1;
    chk("lh_data", wdata_o, 32'hFFFFBEEF);
    chk("lh_flags", {valid_o, wreg_o, misalign_o}, 3'b110);
`endif

    // LHU 0x002 then a back-to-back SW accepted right after the ack
    issue(LHU_OP, 32'h002, 32'h0, 5'd12, 1'b1, 32'h0);
    tick(); valid_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h1234ABCD; #1;
    chk("lhu_sel", bus_sel_o, 4'b0011);
    tick(); bus_ack_i = 1'b0;
    issue(SW_OP, 32'h010, 32'hCAFEF00D, 5'd0, 1'b0, 32'h0);
    chk("lhu_data", wdata_o, 32'h0000ABCD);
    chk("b2b_stall", stallreq_o, 1);
    tick(); valid_i = 1'b0; bus_ack_i = 1'b1; #1;
    chk("sw_sel", bus_sel_o, 4'b1111);
    chk("sw_bwdata", bus_wdata_o, 32'hCAFEF00D);
    chk("sw_addr", bus_addr_o, 32'h10);
    tick(); bus_ack_i = 1'b0; #1;
    chk("sw_done", {valid_o, wreg_o, bus_req_o}, 3'b100);

    // Ack while IDLE is ignored
    bus_ack_i = 1'b1; tick(); bus_ack_i = 1'b0; #1;
    chk("idle_ack", {valid_o, bus_req_o, bus_err_o}, 3'b000);

    // Reset on the second BUSY cycle of an LW, then an ADD
    issue(LW_OP, 32'h400, 32'h0, 5'd6, 1'b1, 32'h0);
    tick(); valid_i = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rst_busy_req", bus_req_o, 0);
    chk("rst_busy_valid", valid_o, 0);
    issue(ADD_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'hDEADBEEF);
    chk("post_rst_stall", stallreq_o, 0);
    tick(); valid_i = 1'b0; #1;
    chk("post_rst_add", {valid_o, wreg_o}, 2'b11);
    chk("post_rst_wdata", wdata_o, 32'hDEADBEEF);
    chk("post_rst_wd", wd_o, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
